// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Definitions shared by the fetch sequencer and the decoder.
//                Holds the opcode values, the instruction-word opcode field
//                position, the sequencer state type and the ALU operation
//                codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcode field position in the default 32-bit instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Opcodes. Every value above OP_JMP is illegal.
  localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_LOAD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SET  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_MULT = 4'b0100;
  localparam logic [OPC_W-1:0] OP_JNZ  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b0111;

  // Sequencer states. ST_PAUSE is reachable only in single-step builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_PAUSE  = 3'd5
  } seq_state_e;

  // ALU operation codes generated by the decoder.
  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_MUL  = 2'd2,
    ALU_NONE = 2'd3
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : Program counter register with clear, load and increment.
//                Priority is clear > load > increment; increment wraps
//                modulo 2^ADDR_W.
//  Ports       : clk, rst_n (async, active-low)
//                clr      - force pc to 0
//                load     - pc <= load_val
//                inc      - pc <= pc + 1
//                load_val - jump target
//                pc       - current value
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Multi-cycle FETCH / DECODE / EXEC control sequencer that owns
//                the program counter and instruction register. Accumulator
//                enable and data-memory write strobes are active only in EXEC.
//  Ports       : clk, rst_n (async, active-low), start
//                imem_req/imem_addr/imem_rdata/imem_ack - instruction fetch
//                opcode/operand  - instruction register fields to decoder
//                pc              - program counter
//                pc_load/dec_mem_wr - decoder results, sampled in EXEC
//                acc_en/dmem_wr  - gated strobes
//                halted/illegal  - status
//                step            - single-step advance (optional build)
//  Options     : FETCH_SEQUENCER_SINGLE_STEP_EN adds the step input and a
//                PAUSE state entered after every EXEC.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  operand,
  output logic [ADDR_W-1:0]  pc,
  input  logic               pc_load,
  input  logic               dec_mem_wr,
  output logic               acc_en,
  output logic               dmem_wr,
  output logic               halted,
  output logic               illegal
);

  seq_state_e         state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               pc_clr, pc_ld, pc_inc;
  logic               ir_ld, ill_set, ill_clr;
  logic               ir_mid_unused;

  assign opcode    = ir[INSTR_W-1 -: OPC_W];
  assign operand   = ir[ADDR_W-1:0];
  assign imem_addr = pc;

  // Bits between the operand and the opcode carry no meaning here.
  assign ir_mid_unused = ^ir[INSTR_W-OPC_W-1:ADDR_W];

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pc_clr),
    .load     (pc_ld),
    .inc      (pc_inc),
    .load_val (operand),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ir_ld) begin
        ir <= imem_rdata;
      end
      if (ill_clr) begin
        illegal <= 1'b0;
      end else if (ill_set) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    acc_en    = 1'b0;
    dmem_wr   = 1'b0;
    halted    = 1'b0;
    pc_clr    = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    ir_ld     = 1'b0;
    ill_set   = 1'b0;
    ill_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pc_clr    = 1'b1;
          ill_clr   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Request and address are held until the memory acknowledges.
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_NOP) begin
          state_nxt = ST_HALT;
        end else if (opcode > OP_JMP) begin
          ill_set   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        acc_en  = (opcode == OP_LOAD) || (opcode == OP_ADD) || (opcode == OP_MULT);
        dmem_wr = dec_mem_wr;
        if (pc_load) begin
          pc_ld = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        state_nxt = ST_PAUSE;
`else
        state_nxt = ST_FETCH;
`endif
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_clr    = 1'b1;
          ill_clr   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) begin
          state_nxt = ST_FETCH;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control sequencer that sits directly upstream of the instruction decoder.
- Owns the program counter and instruction register, and fetches 32-bit instruction words over a request/acknowledge instruction-memory port.
- Presents the opcode to the decoder, then consumes the decoder's pc_load and mem_wr results.
- Gates the accumulator-enable and data-memory write strobes so that each one is active for exactly one EXEC cycle per instruction.

Parameters:
- ADDR_W, 8, width of the PC, operand field and instruction address.
- INSTR_W, 32, instruction word width. Opcode is bits [INSTR_W-1:INSTR_W-4]; operand is bits [ADDR_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level, sampled in IDLE/HALT; begins execution at address 0.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address, equal to pc.
- imem_rdata  in  INSTR_W  fetched word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete; any number of wait cycles is allowed.
- opcode  out  4  instruction-register opcode field, to the decoder.
- operand  out  ADDR_W  instruction-register address field, to the data memory and as the jump target.
- pc  out  ADDR_W  current program counter.
- pc_load  in  1  from the decoder; take the jump.
- dec_mem_wr  in  1  from the decoder; store request.
- acc_en  out  1  accumulator load strobe.
- dmem_wr  out  1  gated data-memory write strobe.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an opcode above 4'b0111 is decoded.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, ir=0.
  - imem_req=0, acc_en=0, dmem_wr=0, halted=0, illegal=0.
- States: IDLE, FETCH, DECODE, EXEC, HALT. The encoding comes from the package.
- IDLE: start=1 -> FETCH with pc=0 and illegal cleared.
- FETCH:
  - imem_req=1, imem_addr=pc; hold both stable until ack.
  - imem_ack=1 -> ir<=imem_rdata, go to DECODE.
  - An ack that arrives without a request is ignored.
- DECODE: one cycle; opcode and operand are stable from ir.
  - opcode=4'b0000 (NOP) -> HALT.
  - opcode>4'b0111 -> illegal<=1, then HALT.
  - Otherwise -> EXEC.
- EXEC: one cycle; pc_load and dec_mem_wr are sampled this cycle only.
  - acc_en=1 iff opcode is LOAD(0001), ADD(0011) or MULT(0100).
  - dmem_wr=dec_mem_wr.
  - pc <= pc_load ? operand : pc+1.
  - Next state is FETCH.
- HALT: halted=1 and pc holds. start=1 -> pc<=0, illegal<=0, go to FETCH.
- start is ignored in FETCH, DECODE and EXEC.
- acc_en and dmem_wr are combinational from state, opcode and dec_mem_wr. Both are 0 outside EXEC.
- Latency: at least 3 cycles per instruction (FETCH, DECODE, EXEC); each FETCH wait cycle adds 1.
- PC increment is modulo 2^ADDR_W; the PC wraps from all-ones to 0 silently.
- A jump to the current pc is legal and forms a tight loop.
- rst_n asserted in any state, including mid-FETCH with imem_req high: all outputs return to their reset values immediately, with no pending-fetch tracking.

Optional Feature:
- Macro: FETCH_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit, pulse) and a PAUSE state.
  - EXEC goes to PAUSE instead of FETCH.
  - PAUSE waits with all strobes 0; a step=1 cycle -> FETCH.
  - halted stays 0 in PAUSE.
- Undefined: no step port and no PAUSE state; EXEC goes to FETCH directly.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams: OP_NOP, OP_LOAD, OP_SET, OP_ADD, OP_MULT, OP_JNZ, OP_JZ, OP_JMP;
  - the sequencer state enum typedef;
  - OPC_MSB/OPC_LSB field positions;
  - the ALU op codes already used by the decoder.
- One sub-module is natural: pc_reg, the ADDR_W-bit register with clear, load and increment, and async active-low reset.

Test Plan:
- Reset, start=1, imem_ack tied high, memory {0:LOAD 5, 1:ADD 6, 2:NOP} -> acc_en pulses at cycle 3 and cycle 6; halted=1 after the third DECODE; pc=2.
- Fetch of word 0x7000_0010 (JMP 0x10), decoder pc_load=1 -> next imem_addr=0x10; dmem_wr stays 0.
- imem_ack delayed 4 cycles -> imem_req and imem_addr stay constant for 4 cycles; instruction period is 7 cycles.
- pc=0xFF executing ADD with pc_load=0 -> next fetch address is 0x00.
- Opcode 4'b1010 fetched -> illegal=1 and halted=1; a start pulse clears illegal and refetches from address 0.
- rst_n dropped mid-FETCH, 2 cycles after the request -> imem_req=0 in the same cycle and state=IDLE; with FETCH_SEQUENCER_SINGLE_STEP_EN defined, one step pulse advances exactly one instruction.
